// File: rtl/comparator_pkg.sv
// Shared types for the serial magnitude comparator.
//   state_t  : controller states (IDLE / COMPARE / DONE)
//   result_t : one-hot result encoding, bit order {GT, LT, EQ};
//              RES_NONE is the state before the first result.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_GT   = 3'b100,
        RES_LT   = 3'b010,
        RES_EQ   = 3'b001
    } result_t;

endpackage

// File: rtl/comparator_serial_if.sv
// Request/result bundle for comparator_serial.
//   start, signed_mode, A, B : request side. The values are captured on the
//                              edge where start is accepted (IDLE or DONE).
//   busy, done               : status. done is a one-cycle pulse.
//   GT, LT, EQ, chunks       : registered result of the last compare.
// Handshake: a request is a single-cycle level on start, with no ready
// signal. It is taken on any edge where the controller is in IDLE or DONE,
// and ignored while busy is high. Completion is the done pulse, and the
// result signals are valid from that cycle until the next done.
interface comparator_serial_if #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(NCHUNK + 1);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             GT;
    logic             LT;
    logic             EQ;
    logic [CNT_W-1:0] chunks;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, GT, LT, EQ, chunks
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, GT, LT, EQ, chunks
    );
endinterface

// File: rtl/comparator_chunk.sv
// Combinational magnitude compare of one CHUNK-bit slice.
//   a, b : slice of operand A and slice of operand B (unsigned)
//   gt   : a > b
//   lt   : a < b
module comparator_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt
);
    assign gt = (a > b);
    assign lt = (a < b);
endmodule

// File: rtl/comparator_serial.sv
// Serial MSB-first comparator. It examines CHUNK bits per clock and stops
// at the first slice that differs.
//   clk, rst  : clock (rising edge), synchronous active-high reset
//   bus       : slave side of comparator_serial_if (request, status, result)
//   fsm_state : current controller state, for observation
module comparator_serial
    import comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst,
    comparator_serial_if.slave  bus,
    output state_t              fsm_state
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CNT_W  = $clog2(NCHUNK + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic [IDX_W-1:0] idx;
    result_t          result_q;
    logic [CNT_W-1:0] chunks_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_gt;
    logic             chunk_lt;

    // Flipping both sign bits maps two's-complement order onto unsigned
    // order. This lets signed mode share the unsigned slice compare.
    // Slice 0 is the top CHUNK bits. The mux selects the slice named by idx.
    always_comb begin
        a_eff          = a_q;
        b_eff          = b_q;
        a_eff[WIDTH-1] = a_q[WIDTH-1] ^ mode_q;
        b_eff[WIDTH-1] = b_q[WIDTH-1] ^ mode_q;
        a_chunk        = '0;
        b_chunk        = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) begin
                a_chunk = a_eff[WIDTH-1-k*CHUNK -: CHUNK];
                b_chunk = b_eff[WIDTH-1-k*CHUNK -: CHUNK];
            end
        end
    end

    comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .gt (chunk_gt),
        .lt (chunk_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            idx      <= '0;
            result_q <= RES_NONE;
            chunks_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        mode_q <= bus.signed_mode;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= COMPARE;
                    end else begin
                        state  <= IDLE;
                    end
                end
                COMPARE: begin
                    // Resolve on the first differing slice, or on the last
                    // slice when every slice before it was equal.
                    if (chunk_gt || chunk_lt || idx == LAST_IDX) begin
                        result_q <= chunk_gt ? RES_GT : (chunk_lt ? RES_LT : RES_EQ);
                        chunks_q <= CNT_W'(idx) + CNT_W'(1);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign {bus.GT, bus.LT, bus.EQ} = result_q;
    assign bus.chunks             = chunks_q;
    assign fsm_state              = state;
endmodule

// File: tb/tb_comparator_serial.sv
module tb_comparator_serial;
    import comparator_pkg::*;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(NCHUNK + 1);
    localparam int RW     = 3 + CNT_W;   // {GT, LT, EQ, chunks}

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             mode;
        logic [RW-1:0]    exp;
    } vec_t;

    logic   clk;
    logic   rst;
    state_t fsm_state;

    comparator_serial_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();

    comparator_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] prev_res;
    int            total;
    int            bad;
    vec_t          vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] cur_res();
        return {bus.GT, bus.LT, bus.EQ, bus.chunks};
    endfunction

    // Reference model. The order is plain integer order, and chunks is the
    // position of the leading differing bit, counted in CHUNK-wide slices.
    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic mode);
        int ia, ib, ch;
        logic [WIDTH-1:0] x;
        if (mode) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'({16'd0, a});
            ib = int'({16'd0, b});
        end
        x  = a ^ b;
        ch = NCHUNK;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[WIDTH-1-i]) begin
                ch = i / CHUNK + 1;
                break;
            end
        end
        return {(ia > ib), (ia < ib), (ia == ib), CNT_W'(ch)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic mode, input logic [RW-1:0] exp);
        bus.A           = a;
        bus.B           = b;
        bus.signed_mode = mode;
        bus.start       = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.A           = WIDTH'($urandom);
        bus.B           = WIDTH'($urandom);
        bus.signed_mode = 1'($urandom);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("done_low_after_start", 32'(bus.done), 32'd0);
        check("hold_after_start", 32'(cur_res()), 32'(prev_res));
    endtask

    // Waits for done. The previous result must hold until then.
    // If inject > 0, a start pulse with A=0 is given in that waiting cycle.
    task automatic wait_result(input int inject);
        bit            seen;
        int            lat;
        logic [RW-1:0] exp;
        seen = 1'b0;
        lat  = 0;
        for (int cyc = 1; cyc <= NCHUNK + 1; cyc++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                lat  = cyc;
                break;
            end
            check("hold_while_busy", 32'(cur_res()), 32'(prev_res));
            check("busy_while_compare", 32'(bus.busy), 32'd1);
            if (cyc == inject) begin
                bus.start = 1'b1;
                bus.A     = '0;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        exp = exp_q.pop_front();
        if (seen) begin
            check("result", 32'(cur_res()), 32'(exp));
            check("latency", 32'(lat), 32'(exp[CNT_W-1:0]));
            check("busy_low_at_done", 32'(bus.busy), 32'd0);
            prev_res = exp;
        end
    endtask

    task automatic idle_after();
        @(posedge clk); #1;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("state_idle", 32'(fsm_state), 32'(IDLE));
        check("hold_in_idle", 32'(cur_res()), 32'(prev_res));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total           = 0;
        bad             = 0;
        prev_res        = '0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.A           = '0;
        bus.B           = '0;

        vecs[0]  = '{16'h1234, 16'h1234, 1'b0, {3'b001, 3'd4}};
        vecs[1]  = '{16'h9000, 16'h1000, 1'b0, {3'b100, 3'd1}};
        vecs[2]  = '{16'h9000, 16'h1000, 1'b1, {3'b010, 3'd1}};
        vecs[3]  = '{16'h1235, 16'h1234, 1'b0, {3'b100, 3'd4}};
        vecs[4]  = '{16'h0001, 16'h0002, 1'b0, {3'b010, 3'd4}};
        vecs[5]  = '{16'hFFFF, 16'h0001, 1'b1, {3'b010, 3'd1}};
        vecs[6]  = '{16'hFFFF, 16'h0001, 1'b0, {3'b100, 3'd1}};
        vecs[7]  = '{16'h7FFF, 16'h8000, 1'b1, {3'b100, 3'd1}};
        vecs[8]  = '{16'h1200, 16'h1300, 1'b0, {3'b010, 3'd2}};
        vecs[9]  = '{16'h1230, 16'h1220, 1'b1, {3'b100, 3'd3}};
        vecs[10] = '{16'h8000, 16'h8000, 1'b1, {3'b001, 3'd4}};
        vecs[11] = '{16'hFFFE, 16'hFFFF, 1'b1, {3'b010, 3'd4}};
        vecs[12] = '{16'h0000, 16'h8000, 1'b1, {3'b100, 3'd1}};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("reset_result", 32'(cur_res()), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp);
            wait_result(0);
            idle_after();
        end

        // A start pulse in the middle of a compare is ignored
        launch(16'h1235, 16'h1234, 1'b0, {3'b100, 3'd4});
        wait_result(1);
        idle_after();

        // Back-to-back: start in the DONE cycle
        launch(16'h0005, 16'h0003, 1'b0, {3'b100, 3'd4});
        wait_result(0);
        launch(16'h0001, 16'h0002, 1'b0, {3'b010, 3'd4});
        wait_result(0);
        idle_after();

        // Randomized stimulus checked against the model
        for (int n = 0; n < 60; n++) begin
            logic [WIDTH-1:0] a, b;
            logic             mode;
            a    = WIDTH'($urandom);
            mode = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                default: b = WIDTH'($urandom);
            endcase
            launch(a, b, mode, model(a, b, mode));
            wait_result(0);
            if ($urandom_range(0, 1) == 0) idle_after();
        end
        idle_after();

        // Reset during a compare: clears everything, and no done follows
        launch(16'h1234, 16'h1234, 1'b0, {3'b001, 3'd4});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        prev_res = '0;
        check("abort_result", 32'(cur_res()), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_state", 32'(fsm_state), 32'(IDLE));
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("no_done_after_abort", 32'(bus.done), 32'd0);
        end

        // The comparator still works after the abort
        launch(16'h9000, 16'h1000, 1'b1, {3'b010, 3'd1});
        wait_result(0);
        idle_after();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
